// File: rtl/jellyvl_synctimer_timer_if.sv
// Timer control bus: set override, adjust beats and the timer value going back out.
interface jellyvl_synctimer_timer_if #(
  parameter int TIMER_WIDTH = 64
);
  logic [TIMER_WIDTH-1:0] set_time;
  logic                   set_valid;
  logic                   adjust_sign;
  logic                   adjust_valid;
  logic                   adjust_ready;
  logic [TIMER_WIDTH-1:0] current_time;

  modport master (
    output set_time, set_valid, adjust_sign, adjust_valid,
    input  adjust_ready, current_time
  );

  modport slave (
    input  set_time, set_valid, adjust_sign, adjust_valid,
    output adjust_ready, current_time
  );
endinterface

// File: rtl/jellyvl_synctimer_timer.sv
// Free-running local timer advancing NUMERATOR/DENOMINATOR units per clock,
// with +/-1 unit slip beats and a hard set override.
module jellyvl_synctimer_timer #(
  parameter int TIMER_WIDTH = 64,
  parameter int NUMERATOR   = 10,
  parameter int DENOMINATOR = 3,
  parameter logic [TIMER_WIDTH-1:0] INIT_TIME = '0
) (
  input logic reset,
  input logic clk,
  jellyvl_synctimer_timer_if.slave bus
);
  localparam int STEP_INT  = NUMERATOR / DENOMINATOR;
  localparam int STEP_FRAC = NUMERATOR % DENOMINATOR;
  // one extra bit so frac + STEP_FRAC (< 2*DENOMINATOR) never overflows
  localparam int FW        = $clog2(DENOMINATOR) + 1;

  logic [TIMER_WIDTH-1:0] time_q, time_d;
  logic [FW-1:0]          frac_q, frac_d;
  logic                   ready_q, ready_d;

  logic [FW-1:0]          sum;
  logic                   carry;
  logic                   accept;
  logic [TIMER_WIDTH-1:0] adj;

  // Next-state: integer step + fractional carry + slip, set overrides everything
  always_comb begin
    sum    = frac_q + FW'(STEP_FRAC);
    carry  = (sum >= FW'(DENOMINATOR));
    accept = bus.adjust_valid & ready_q;
    adj    = '0;
    if (accept) adj = bus.adjust_sign ? '1 : TIMER_WIDTH'(1);
    frac_d = carry ? (sum - FW'(DENOMINATOR)) : sum;
    time_d = time_q + TIMER_WIDTH'(STEP_INT) + {{(TIMER_WIDTH-1){1'b0}}, carry} + adj;
    // the handshake still completes on a set; only the slip itself is dropped
    ready_d = ~accept;
    if (bus.set_valid) begin
      time_d = bus.set_time;
      frac_d = '0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      time_q  <= INIT_TIME;
      frac_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      time_q  <= time_d;
      frac_q  <= frac_d;
      ready_q <= ready_d;
    end
  end

  assign bus.current_time = time_q;
  assign bus.adjust_ready = ready_q;
endmodule

// File: tb/tb_jellyvl_synctimer_timer.sv
// Self-checking bench: directed scenarios plus random adjust/set/reset streams
// compared against an exact-rational reference model.
module tb_jellyvl_synctimer_timer;
  localparam int NUM = 10;
  localparam int DEN = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  jellyvl_synctimer_timer_if #(.TIMER_WIDTH(64)) bus();

  jellyvl_synctimer_timer #(
    .TIMER_WIDTH(64), .NUMERATOR(NUM), .DENOMINATOR(DEN), .INIT_TIME(64'd0)
  ) dut (
    .reset(reset),
    .clk  (clk),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: time = base + floor(n*NUM/DEN) + net slips, n = clocks since reset/set
  logic [63:0] m_base;
  longint      m_n;
  longint      m_adj;
  logic        m_rdy;
  logic [63:0] m_exp;

  task automatic tick();
    logic acc;
    acc = bus.adjust_valid && m_rdy;
    @(posedge clk);
    if (!reset) begin
      m_base = 64'd0; m_n = 0; m_adj = 0; m_rdy = 1'b0;
    end else begin
      if (bus.set_valid) begin
        m_base = bus.set_time; m_n = 0; m_adj = 0;
      end else begin
        m_n = m_n + 1;
        if (acc) m_adj = m_adj + (bus.adjust_sign ? -1 : 1);
      end
      m_rdy = !acc;
    end
    m_exp = m_base + 64'((m_n * NUM) / DEN) + 64'(m_adj);
    #1;
  endtask

  task automatic idle_inputs();
    bus.set_valid = 1'b0; bus.set_time = '0;
    bus.adjust_valid = 1'b0; bus.adjust_sign = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    checks++;
    if (bus.current_time !== 64'd0) begin
      errors++; $display("FAIL reset_time got=%0d want=0", bus.current_time);
    end
    checks++;
    if (bus.adjust_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got=%0b want=0", bus.adjust_ready);
    end
  endtask

  task automatic test_freerun();
    logic [63:0] exp_t [7];
    exp_t = '{64'd3, 64'd6, 64'd10, 64'd13, 64'd16, 64'd20, 64'd23};
    idle_inputs();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (bus.current_time !== exp_t[i]) begin
        errors++; $display("FAIL freerun[%0d] got=%0d want=%0d", i, bus.current_time, exp_t[i]);
      end
    end
    checks++;
    if (bus.adjust_ready !== 1'b1) begin
      errors++; $display("FAIL freerun_ready got=%0b want=1", bus.adjust_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_t [6];
    logic        exp_r [6];
    exp_t = '{64'd3, 64'd7, 64'd11, 64'd15, 64'd18, 64'd23};
    exp_r = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    idle_inputs();
    do_reset();
    bus.adjust_valid = 1'b1; bus.adjust_sign = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.current_time !== exp_t[i] || bus.adjust_ready !== exp_r[i]) begin
        errors++;
        $display("FAIL b2b[%0d] got t=%0d r=%0b want t=%0d r=%0b",
                 i, bus.current_time, bus.adjust_ready, exp_t[i], exp_r[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_minus_on_carry();
    logic [63:0] exp_t [4];
    exp_t = '{64'd3, 64'd6, 64'd9, 64'd12};
    idle_inputs();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      // beat presented only for the third edge, which is a carry edge
      bus.adjust_valid = (i == 2); bus.adjust_sign = 1'b1;
      tick();
      checks++;
      if (bus.current_time !== exp_t[i]) begin
        errors++; $display("FAIL minus[%0d] got=%0d want=%0d", i, bus.current_time, exp_t[i]);
      end
      if (i == 2) begin
        checks++;
        if (bus.adjust_ready !== 1'b0) begin
          errors++; $display("FAIL minus_ready got=%0b want=0", bus.adjust_ready);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_set_with_adjust();
    logic [63:0] exp_t [4];
    exp_t = '{64'h1000, 64'h1003, 64'h1006, 64'h100A};
    idle_inputs();
    do_reset();
    tick(); tick();               // frac is now 2, ready is 1
    bus.set_valid = 1'b1; bus.set_time = 64'h1000;
    bus.adjust_valid = 1'b1; bus.adjust_sign = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        idle_inputs();
        checks++;
        if (bus.adjust_ready !== 1'b0) begin
          errors++; $display("FAIL set_adj_ready got=%0b want=0", bus.adjust_ready);
        end
      end
      checks++;
      if (bus.current_time !== exp_t[i]) begin
        errors++; $display("FAIL set_adj[%0d] got=%0h want=%0h", i, bus.current_time, exp_t[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_t [4];
    exp_t = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'd4, 64'd8};
    idle_inputs();
    do_reset();
    tick();
    bus.set_valid = 1'b1; bus.set_time = 64'hFFFF_FFFF_FFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_inputs();
      checks++;
      if (bus.current_time !== exp_t[i]) begin
        errors++; $display("FAIL wrap[%0d] got=%0h want=%0h", i, bus.current_time, exp_t[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] exp_t [3];
    exp_t = '{64'd3, 64'd6, 64'd10};
    idle_inputs();
    do_reset();
    bus.adjust_valid = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (bus.current_time !== 64'd0 || bus.adjust_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset got t=%0d r=%0b want t=0 r=0", bus.current_time, bus.adjust_ready);
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.current_time !== exp_t[i]) begin
        errors++; $display("FAIL midreset_resume[%0d] got=%0d want=%0d", i, bus.current_time, exp_t[i]);
      end
      if (i == 0) begin
        checks++;
        if (bus.adjust_ready !== 1'b1) begin
          errors++; $display("FAIL midreset_ready got=%0b want=1", bus.adjust_ready);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] prev;
    logic        excl;
    idle_inputs();
    do_reset();
    prev = bus.current_time;
    for (int i = 0; i < 2000; i++) begin
      // an unaccepted beat keeps valid and sign stable
      if (!(bus.adjust_valid && !bus.adjust_ready)) begin
        bus.adjust_valid = ($urandom_range(0, 2) != 0);
        bus.adjust_sign  = $urandom_range(0, 1);
      end
      bus.set_valid = ($urandom_range(0, 15) == 0);
      bus.set_time  = {32'd0, $urandom};
      reset         = ($urandom_range(0, 99) != 0);
      excl          = bus.set_valid || !reset;
      tick();
      checks++;
      if (bus.current_time !== m_exp || bus.adjust_ready !== m_rdy) begin
        errors++;
        $display("FAIL rand[%0d] got t=%0d r=%0b want t=%0d r=%0b",
                 i, bus.current_time, bus.adjust_ready, m_exp, m_rdy);
      end
      if (!excl) begin
        checks++;
        if (bus.current_time < prev) begin
          errors++; $display("FAIL monotonic[%0d] got=%0d prev=%0d", i, bus.current_time, prev);
        end
      end
      prev = bus.current_time;
    end
    reset = 1'b1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_base = 64'd0; m_n = 0; m_adj = 0; m_rdy = 1'b0; m_exp = 64'd0;
    test_reset();
    test_freerun();
    test_back_to_back();
    test_minus_on_carry();
    test_set_with_adjust();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
